// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with a valid/ready grant handshake. An optional lock
// keeps a stalled grant in place while its request stays asserted.
module rr_lock_arbiter #(
  parameter int NUM_REQS    = 4,
  parameter bit LOCK_ENABLE = 1'b1,
  parameter int LN          = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] requests,
  output logic                grant_valid,
  output logic [NUM_REQS-1:0] grant_onehot,
  output logic [LN-1:0]       grant_index,
  input  logic                grant_ready
);

  logic [LN-1:0] last_idx_r;
  logic          lock_valid_r;
  logic [LN-1:0] lock_idx_r;

  logic [LN-1:0] rr_idx;
  logic          rr_found;
  logic          lock_req;
  logic [LN-1:0] sel_idx;
  logic          any_req;

  // Two passes give the wrapped priority order: first the indices above
  // last_idx_r, then from 0 upward. Constant loop indices keep every select in range.
  // NOTE: every always_comb output gets a default first, so no path can leave
  // a variable unassigned and infer a latch.
  always_comb begin
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (!rr_found && requests[i] && (LN'(i) > last_idx_r)) begin
        rr_found = 1'b1;
        rr_idx   = LN'(i);
      end
    end
    for (int i = 0; i < NUM_REQS; i++) begin
      if (!rr_found && requests[i]) begin
        rr_found = 1'b1;
        rr_idx   = LN'(i);
      end
    end
  end

  always_comb begin
    lock_req = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (requests[i] && (LN'(i) == lock_idx_r)) begin
        lock_req = 1'b1;
      end
    end
  end

  // The lock only overrides while the locked requester is still asking.
  always_comb begin
    sel_idx = rr_idx;
    if (LOCK_ENABLE && lock_valid_r && lock_req) begin
      sel_idx = lock_idx_r;
    end
  end

  assign any_req     = |requests;
  assign grant_valid = any_req && !reset;
  assign grant_index = grant_valid ? sel_idx : '0;

  always_comb begin
    grant_onehot = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      grant_onehot[i] = grant_valid && (sel_idx == LN'(i));
    end
  end

  // NOTE: state registers use non-blocking assignments so every update sees
  // the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_idx_r   <= LN'(NUM_REQS - 1);
      lock_valid_r <= 1'b0;
      lock_idx_r   <= '0;
    end else if (grant_valid) begin
      if (grant_ready) begin
        last_idx_r   <= grant_index;
        lock_valid_r <= 1'b0;
      end else begin
        lock_valid_r <= LOCK_ENABLE;
        lock_idx_r   <= grant_index;
      end
    end else begin
      lock_valid_r <= 1'b0;
    end
  end

endmodule
